sipo_frame_ctrl: RTL

- Receive-side controller that sequences a parameterized serial-in/parallel-out shift stage.
- Frames WIDTH serial bits after a start marker and counts bits.
- Latches each completed word into an output holding register and hands it downstream with a valid/ready handshake.
- Sits between a serial link front-end and any parallel consumer; flags overrun when the consumer stalls.

---
 rtl/sipo_pkg.sv | 12 +
 rtl/sipo_frame_ctrl_if.sv | 31 +++
 rtl/sipo_shift_stage.sv | 23 ++
 rtl/sipo_frame_ctrl.sv | 97 +++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and constants for the SIPO frame controller.
// Imported by the interface, shift stage and controller.
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int SIPO_DEF_WIDTH = 4;

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Serial-in and parallel-out signal bundle of the SIPO frame controller.
// The master side feeds serial bits and consumes words; the slave side is the controller.
interface sipo_frame_ctrl_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEF_WIDTH
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             sin;
    logic             sin_valid;
    logic             start;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;
    logic             overrun;
    logic             clr_ovr;

    modport master (
        output sin, sin_valid, start, dout_ready, clr_ovr,
        input  dout, dout_valid, busy, bit_cnt, overrun
    );

    modport slave (
        input  sin, sin_valid, start, dout_ready, clr_ovr,
        output dout, dout_valid, busy, bit_cnt, overrun
    );

endinterface

// File: rtl/sipo_shift_stage.sv
// Enabled shift-left register; new bits enter at index 0.
// Async active-low reset clears the stage.
module sipo_shift_stage
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= {q[WIDTH-2:0], sin};
        end
    end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frames WIDTH serial bits after a start marker and hands each word
// downstream through a holding register with valid/ready and sticky overrun.
module sipo_frame_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    sipo_frame_ctrl_if.slave bus
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             busy_r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] dout_r;
    logic             dv_r;
    logic             ovr_r;
    logic             shift_en;
    logic             last;
    logic             done;
    logic             ovr_set;

    // Start is honoured in either state; plain bits only inside a frame.
    assign shift_en = bus.sin_valid && (bus.start || state == SHIFT);
    assign last     = (cnt == CNT_W'(WIDTH - 1));
    assign done     = bus.sin_valid && !bus.start && state == SHIFT && last;
    assign word     = {q[WIDTH-2:0], bus.sin};
    assign ovr_set  = done && dv_r && !bus.dout_ready;

    sipo_shift_stage #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (shift_en),
        .sin  (bus.sin),
        .q    (q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_r <= 1'b0;
        end else if (bus.sin_valid) begin
            if (bus.start) begin
                state  <= SHIFT;
                cnt    <= CNT_W'(1);
                busy_r <= 1'b1;
            end else if (state == SHIFT) begin
                if (last) begin
                    state  <= IDLE;
                    cnt    <= '0;
                    busy_r <= 1'b0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // A word lands whenever the slot is free or being drained this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r <= '0;
            dv_r   <= 1'b0;
        end else if (done) begin
            if (!dv_r || bus.dout_ready) begin
                dout_r <= word;
                dv_r   <= 1'b1;
            end
        end else if (dv_r && bus.dout_ready) begin
            dv_r <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_r <= 1'b0;
        end else if (ovr_set) begin
            ovr_r <= 1'b1;
        end else if (bus.clr_ovr) begin
            ovr_r <= 1'b0;
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dv_r;
    assign bus.busy       = busy_r;
    assign bus.bit_cnt    = cnt;
    assign bus.overrun    = ovr_r;

endmodule
